// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - control and serial-output bundle for seq_pattern_tx
interface seq_pattern_tx_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic                 abort;
  logic [CNT_WIDTH-1:0] repeat_cnt;
  logic                 out_bit;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, repeat_cnt,
    input  out_bit, out_valid, busy, done
  );

  modport slave (
    input  start, abort, repeat_cnt,
    output out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - repeats a fixed bit pattern MSB first, a programmable number of times
module seq_pattern_tx #(
  parameter int                   PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  seq_pattern_tx_if.slave    bus
);

  localparam int IDX_W = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [CNT_WIDTH-1:0] rep_cnt;
  logic [CNT_WIDTH-1:0] cnt_lat;
  logic                 accept;
  logic                 last_bit;

  // start is only honoured from IDLE, and a simultaneous abort vetoes it
  assign accept   = (state == ST_IDLE) && bus.start && !bus.abort;
  // last bit of the last repetition; rep_cnt stops here so it can never wrap
  assign last_bit = (bit_idx == LAST_IDX) && (rep_cnt == cnt_lat);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_SEND;
      ST_SEND: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // bit position, repetition count and the count latched at start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx <= '0;
      rep_cnt <= '0;
      cnt_lat <= '0;
    end else if (accept) begin
      bit_idx <= '0;
      rep_cnt <= '0;
      cnt_lat <= bus.repeat_cnt;
    end else if (state == ST_SEND) begin
      if (bus.abort || last_bit) begin
        bit_idx <= '0;
        rep_cnt <= '0;
      end else if (bit_idx == LAST_IDX) begin
        bit_idx <= '0;
        rep_cnt <= rep_cnt + 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // outputs decoded from registered state only; out_bit is forced low outside SEND
  always_comb begin
    bus.out_bit   = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      ST_SEND: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out_bit   = PATTERN[LAST_IDX - bit_idx];
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
